// File: rtl/alu_mdu_if.sv
// alu_mdu request/result bundle.
// Master issues ops, slave returns results.
interface alu_mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             ovf;

  modport master (
    output start, op, busA, busB,
    input  busy, done, lo, hi, zero, ovf
  );

  modport slave (
    input  start, op, busA, busB,
    output busy, done, lo, hi, zero, ovf
  );
endinterface

// File: rtl/alu_mdu.sv
// EX-stage ALU with iterative unsigned mul/div.
// Single-cycle ALU ops; MULTU/DIVU take WIDTH cycles.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic   clk,
  input logic   rst,
  alu_mdu_if.slave io
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a, b, sum, diff;
  logic             ovf_add, ovf_sub, slt;
  logic [WIDTH:0]   mul_sum, div_try, div_sub;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_rem, div_quo;
  logic             div_ge, last;

  assign a = io.busA;
  assign b = io.busB;

  // Single-cycle ALU results and one mul/div iteration step
  always_comb begin
    sum     = a + b;
    diff    = a - b;
    ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    slt     = $signed(a) < $signed(b);
    mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opr_q} : '0);
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], sh_q[WIDTH-1:1]};
    div_try = {acc_q, sh_q[WIDTH-1]};
    div_sub = div_try - {1'b0, opr_q};
    div_ge  = !div_sub[WIDTH];
    div_rem = div_ge ? div_sub[WIDTH-1:0] : div_try[WIDTH-1:0];
    div_quo = {sh_q[WIDTH-2:0], div_ge};
    last    = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state, iteration and result update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opr_d   = opr_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          unique case (io.op)
            OP_ADD: begin
              lo_d   = sum;
              zero_d = (sum == '0);
              ovf_d  = ovf_add;
              done_d = 1'b1;
            end
            OP_SUB: begin
              lo_d   = diff;
              zero_d = (diff == '0);
              ovf_d  = ovf_sub;
              done_d = 1'b1;
            end
            OP_OR: begin
              lo_d   = a | b;
              zero_d = ((a | b) == '0);
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_AND: begin
              lo_d   = a & b;
              zero_d = ((a & b) == '0);
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_SLT: begin
              lo_d   = {{(WIDTH-1){1'b0}}, slt};
              zero_d = !slt;
              ovf_d  = 1'b0;
              done_d = 1'b1;
            end
            OP_MUL: begin
              opr_d   = a;
              sh_d    = b;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = MUL;
            end
            OP_DIV: begin
              if (b == '0) begin
                lo_d   = '1;
                hi_d   = a;
                zero_d = 1'b0;
                ovf_d  = 1'b0;
                done_d = 1'b1;
              end else begin
                opr_d   = b;
                sh_d    = a;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = DIV;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      MUL: begin
        acc_d = mul_hi;
        sh_d  = mul_lo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          zero_d  = (mul_lo == '0);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DIV: begin
        acc_d = div_rem;
        sh_d  = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          hi_d    = div_rem;
          lo_d    = div_quo;
          zero_d  = (div_quo == '0);
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sh_q    <= '0;
      opr_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opr_q   <= opr_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign io.busy = (state_q != IDLE);
  assign io.done = done_q;
  assign io.lo   = lo_q;
  assign io.hi   = hi_q;
  assign io.zero = zero_q;
  assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed + scoreboard bench for alu_mdu.
// Reference results come from plain SV arithmetic.
module tb_alu_mdu;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   passed;
  int   total;
  exp_t sb[$];
  exp_t m;

  alu_mdu_if #(.WIDTH(W)) io ();

  alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0]   r;
    logic [2*W-1:0] p;
    case (op)
      3'd0: begin
        r = a + b;
        m.lo = r; m.zero = (r == 0);
        m.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd1: begin
        r = a - b;
        m.lo = r; m.zero = (r == 0);
        m.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      3'd2: begin
        r = a | b; m.lo = r; m.zero = (r == 0); m.ovf = 0;
      end
      3'd3: begin
        r = a & b; m.lo = r; m.zero = (r == 0); m.ovf = 0;
      end
      3'd4: begin
        r = ($signed(a) < $signed(b)) ? 1 : 0;
        m.lo = r; m.zero = (r == 0); m.ovf = 0;
      end
      3'd5: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m.hi = p[2*W-1:W]; m.lo = p[W-1:0];
        m.zero = (m.lo == 0); m.ovf = 0;
      end
      3'd6: begin
        if (b == 0) begin
          m.lo = '1; m.hi = a; m.zero = 0; m.ovf = 0;
        end else begin
          m.lo = a / b; m.hi = a % b;
          m.zero = (m.lo == 0); m.ovf = 0;
        end
      end
      default: ;
    endcase
    sb.push_back(m);
  endtask

  task automatic cmp_sb(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_lo"}, 64'(io.lo), 64'(e.lo));
      chk({tag, "_hi"}, 64'(io.hi), 64'(e.hi));
      chk({tag, "_zero"}, 64'(io.zero), 64'(e.zero));
      chk({tag, "_ovf"}, 64'(io.ovf), 64'(e.ovf));
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input int busy_exp, input int poke);
    int n;
    int nb;
    model(op, a, b);
    io.start = 1'b1; io.op = op; io.busA = a; io.busB = b;
    @(posedge clk); #1;
    io.start = 1'b0;
    n = 0; nb = 0;
    while (!io.done && n < 100) begin
      if (io.busy) nb++;
      if (n == poke) begin
        io.start = 1'b1; io.op = 3'd0; io.busA = 1; io.busB = 1;
      end else begin
        io.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    io.start = 1'b0;
    chk({tag, "_no_timeout"}, 64'(n < 100), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'(busy_exp));
    chk({tag, "_busy_in_done"}, 64'(io.busy), 64'd0);
    cmp_sb(tag);
  endtask

  initial begin
    int dones;
    int n;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    passed = 0; total = 0;
    io.start = 0; io.op = 0; io.busA = 0; io.busB = 0;
    m.lo = 0; m.hi = 0; m.zero = 1; m.ovf = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lo", 64'(io.lo), 64'd0);
    chk("rst_hi", 64'(io.hi), 64'd0);
    chk("rst_zero", 64'(io.zero), 64'd1);
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_done", 64'(io.done), 64'd0);
    chk("rst_ovf", 64'(io.ovf), 64'd0);
    rst = 1'b0;

    run("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'd1, 0, -1);
    chk("add_ovf_lo_const", 64'(io.lo), 64'h8000_0000);
    run("sub_zero", 3'd1, 32'd5, 32'd5, 0, -1);
    run("sub_ovf", 3'd1, 32'h8000_0000, 32'd1, 0, -1);
    run("slt_neg", 3'd4, 32'hFFFF_FFFF, 32'd1, 0, -1);
    chk("slt_lo_const", 64'(io.lo), 64'd1);
    run("slt_pos", 3'd4, 32'd1, 32'hFFFF_FFFF, 0, -1);
    run("or", 3'd2, 32'hF0F0_0000, 32'h0000_0F0F, 0, -1);
    run("and", 3'd3, 32'hF0F0_0000, 32'h0F0F_FFFF, 0, -1);

    run("mul_max", 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W, 5);
    chk("mul_hi_const", 64'(io.hi), 64'hFFFF_FFFE);
    chk("mul_lo_const", 64'(io.lo), 64'h1);
    @(posedge clk); #1;
    chk("mul_no_extra_done", 64'(io.done), 64'd0);

    run("div_100_7", 3'd6, 32'd100, 32'd7, W, -1);
    chk("div_lo_const", 64'(io.lo), 64'd14);
    chk("div_hi_const", 64'(io.hi), 64'd2);
    run("div_by0", 3'd6, 32'd9, 32'd0, 0, -1);
    run("op111", 3'd7, 32'd123, 32'd456, 0, -1);

    model(3'd5, 32'd3, 32'd4);
    io.start = 1; io.op = 3'd5; io.busA = 3; io.busB = 4;
    @(posedge clk); #1;
    n = 0;
    while (!io.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_no_timeout", 64'(n < 100), 64'd1);
    cmp_sb("b2b_mul");
    model(3'd0, 32'd1, 32'd1);
    io.op = 3'd0; io.busA = 1; io.busB = 1;
    @(posedge clk); #1;
    io.start = 0;
    chk("b2b_add_done", 64'(io.done), 64'd1);
    cmp_sb("b2b_add");

    io.start = 1; io.op = 3'd6; io.busA = 1000; io.busB = 3;
    @(posedge clk); #1;
    io.start = 0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    dones = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m.lo = 0; m.hi = 0; m.zero = 1; m.ovf = 0;
    for (int i = 0; i < 40; i++) begin
      if (io.done) dones++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_busy", 64'(io.busy), 64'd0);
    chk("abort_lo", 64'(io.lo), 64'd0);
    chk("abort_hi", 64'(io.hi), 64'd0);
    chk("abort_zero", 64'(io.zero), 64'd1);
    run("div_after_abort", 3'd6, 32'd1000, 32'd3, W, -1);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra = $urandom;
      rb = (i == 3) ? 0 : $urandom;
      if (rop == 3'd6 && i > 4) rb = 32'($urandom_range(1, 1000));
      run("rand", rop, ra, rb,
          ((rop == 3'd5) || (rop == 3'd6 && rb != 0)) ? W : 0, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
